// File: rtl/addsub_serial.sv
`default_nettype none
// ============================================================================
// Module      : addsub_serial
// Description : Digit-serial signed adder/subtractor, LSB first, DIGIT bits per
//               cycle, valid/ready on both sides, carry/overflow/saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic             sat,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0]    C_LAST    = CW'(N - 1);
    localparam logic [WIDTH-1:0] C_MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] C_MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_param_check
            $error("addsub_serial: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cy_q;
    logic             sat_q;
    logic             sign_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             ovf_q;

    logic [DIGIT:0]   w_dig;
    logic [DIGIT-1:0] w_dsum;
    logic             w_cout;
    logic             w_cin_msb;
    logic             w_ovf;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_word;

    assign w_dig  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, cy_q};
    assign w_dsum = w_dig[DIGIT-1:0];
    assign w_cout = w_dig[DIGIT];
    // Carry into the top bit of this digit, recovered from its sum bit.
    assign w_cin_msb = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ w_dsum[DIGIT-1];
    assign w_ovf     = w_cin_msb ^ w_cout;
    assign w_last    = (cnt_q == C_LAST);
    assign w_accept  = (state_q == S_IDLE) && in_valid;

    generate
        if (DIGIT == WIDTH) begin : g_single
            assign w_word = w_dsum;
        end else begin : g_multi
            logic [WIDTH-DIGIT-1:0] psum_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    psum_q <= '0;
                end else if (state_q == S_RUN) begin
                    psum_q <= w_word[WIDTH-1:DIGIT];
                end
            end
            assign w_word = {w_dsum, psum_q};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)  state_d = S_RUN;
            S_RUN:   if (w_last)    state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            cy_q     <= 1'b0;
            sat_q    <= 1'b0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (w_accept) begin
            a_q    <= operand_a;
            b_q    <= mode ? ~operand_b : operand_b;
            cy_q   <= mode;
            sat_q  <= sat;
            sign_q <= operand_a[WIDTH-1];
            cnt_q  <= '0;
        end else if (state_q == S_RUN) begin
            a_q   <= a_q >> DIGIT;
            b_q   <= b_q >> DIGIT;
            cy_q  <= w_cout;
            cnt_q <= cnt_q + CW'(1);
            if (w_last) begin
                carry_q  <= w_cout;
                ovf_q    <= w_ovf;
                result_q <= (sat_q && w_ovf) ? (sign_q ? C_MAX_NEG : C_MAX_POS) : w_word;
            end
        end
    end

    assign result   = result_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_addsub_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_serial
// Description : Scoreboard bench for addsub_serial (8/2 directed, 4/1 and 4/4 sweep).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       iv8, ir8, m8, s8, ov8, or8, c8, o8;
    logic [7:0] a8, b8, r8;

    logic [3:0] a4, b4;
    logic       m4, s4;
    logic       iv1, ir1, ov1, c1, o1;
    logic       iv4, ir4, ov4, c4, o4;
    logic [3:0] r1, r4;
    logic       or4b;

    addsub_serial #(.WIDTH(8), .DIGIT(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .mode(m8), .sat(s8),
        .operand_a(a8), .operand_b(b8), .out_valid(ov8), .out_ready(or8),
        .result(r8), .carry(c8), .overflow(o8)
    );

    addsub_serial #(.WIDTH(4), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .mode(m4), .sat(s4),
        .operand_a(a4), .operand_b(b4), .out_valid(ov1), .out_ready(or4b),
        .result(r1), .carry(c1), .overflow(o1)
    );

    addsub_serial #(.WIDTH(4), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .mode(m4), .sat(s4),
        .operand_a(a4), .operand_b(b4), .out_valid(ov4), .out_ready(or4b),
        .result(r4), .carry(c4), .overflow(o4)
    );

    int checks   = 0;
    int failures = 0;

    // Expected entries are {carry, overflow, result}.
    logic [9:0] q8[$];
    logic [5:0] q1[$];
    logic [5:0] q4[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for DUT, expected response within bound", name);
    endtask

    function automatic logic [5:0] ref4(input int ua, input int ub, input logic m, input logic s);
        int sa, sb, t, u;
        logic ov, cy;
        logic [3:0] r;
        sa = (ua >= 8) ? ua - 16 : ua;
        sb = (ub >= 8) ? ub - 16 : ub;
        t  = m ? sa - sb : sa + sb;
        ov = (t > 7) || (t < -8);
        u  = m ? ua + (15 - ub) + 1 : ua + ub;
        cy = (u >= 16);
        r  = 4'(t);
        if (s && ov) r = (t < 0) ? 4'h8 : 4'h7;
        return {cy, ov, r};
    endfunction

    always @(negedge clk) begin
        if (rst_n && ov8 && or8) begin
            if (q8.size() == 0) timeout_fail("out8_unexpected");
            else chk("out8 {c,o,res}", {c8, o8, r8}, q8.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov1 && or4b) begin
            if (q1.size() == 0) timeout_fail("sweep_d1_unexpected");
            else chk($sformatf("sweep_d1 a=%0h b=%0h m=%0b s=%0b", a4, b4, m4, s4),
                     {c1, o1, r1}, q1.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov4 && or4b) begin
            if (q4.size() == 0) timeout_fail("sweep_d4_unexpected");
            else chk($sformatf("sweep_d4 a=%0h b=%0h m=%0b s=%0b", a4, b4, m4, s4),
                     {c4, o4, r4}, q4.pop_front());
        end
    end

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic m,
                          input logic s, input logic [9:0] exp);
        int t;
        t = 0;
        @(posedge clk); #2;
        a8 = a; b8 = b; m8 = m; s8 = s; iv8 = 1'b1;
        while (!ir8 && t < 50) begin
            @(posedge clk); #2;
            t++;
        end
        if (t >= 50) timeout_fail("issue8_accept");
        q8.push_back(exp);
        @(posedge clk); #1;
        iv8 = 1'b0;
    endtask

    task automatic wait_out8(output int lat);
        lat = 0;
        while (!ov8 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 50) timeout_fail("wait_out8");
    endtask

    task automatic wait_idle8();
        int t;
        t = 0;
        while (!ir8 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) timeout_fail("wait_idle8");
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic m,
                        input logic s, input logic [9:0] exp);
        int lat;
        issue8(a, b, m, s, exp);
        wait_out8(lat);
        wait_idle8();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int t;
        rst_n = 1'b0;
        iv8 = 1'b0; m8 = 1'b0; s8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b1;
        iv1 = 1'b0; iv4 = 1'b0; a4 = '0; b4 = '0; m4 = 1'b0; s4 = 1'b0; or4b = 1'b1;
        #12;
        chk("rst_in_ready",  ir8, 1);
        chk("rst_out_valid", ov8, 0);
        chk("rst_result",    r8,  0);
        chk("rst_carry",     c8,  0);
        chk("rst_overflow",  o8,  0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Add without overflow, with latency check.
        issue8(8'd100, 8'd27, 1'b0, 1'b0, {1'b0, 1'b0, 8'h7F});
        wait_out8(lat);
        chk("latency_add", lat, 4);
        wait_idle8();

        run8(8'd100, 8'd28, 1'b0, 1'b0, {1'b0, 1'b1, 8'h80});
        run8(8'd100, 8'd28, 1'b0, 1'b1, {1'b0, 1'b1, 8'h7F});
        run8(8'h80,  8'h01, 1'b1, 1'b0, {1'b1, 1'b1, 8'h7F});
        run8(8'h80,  8'h01, 1'b1, 1'b1, {1'b1, 1'b1, 8'h80});
        run8(8'd5,   8'd7,  1'b1, 1'b0, {1'b0, 1'b0, 8'hFE});
        run8(8'hFF,  8'hFF, 1'b0, 1'b0, {1'b1, 1'b0, 8'hFE});
        run8(8'h80,  8'hFF, 1'b0, 1'b1, {1'b1, 1'b1, 8'h80});
        run8(8'h7F,  8'h80, 1'b1, 1'b1, {1'b0, 1'b1, 8'h7F});

        // Backpressure with ignored in_valid pulses during RUN and DONE.
        @(posedge clk); #2;
        or8 = 1'b0;
        issue8(8'd10, 8'd20, 1'b0, 1'b0, {1'b0, 1'b0, 8'h1E});
        #1;
        a8 = 8'h55; b8 = 8'h11; m8 = 1'b1; s8 = 1'b1; iv8 = 1'b1;
        t = 0;
        while (t < 10) begin
            if (ov8) break;
            chk("bp_run_in_ready", ir8, 0);
            @(posedge clk); #1;
            t++;
        end
        if (t >= 10) timeout_fail("bp_out_valid");
        for (int i = 0; i < 5; i++) begin
            chk("bp_done_out_valid", ov8, 1);
            chk("bp_done_in_ready",  ir8, 0);
            chk("bp_done_result",    {c8, o8, r8}, {1'b0, 1'b0, 8'h1E});
            @(posedge clk); #1;
        end
        #1;
        iv8 = 1'b0;
        or8 = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", ov8, 0);
        chk("bp_release_in_ready",  ir8, 1);
        repeat (8) @(posedge clk);
        #1;
        chk("bp_no_stray_output", ov8, 0);

        // Asynchronous reset in the middle of RUN.
        issue8(8'd50, 8'd60, 1'b0, 1'b0, {1'b0, 1'b0, 8'd110});
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready",  ir8, 1);
        chk("midrst_out_valid", ov8, 0);
        chk("midrst_result",    r8,  0);
        chk("midrst_flags",     {c8, o8}, 0);
        q8.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        run8(8'd3, 8'd4, 1'b0, 1'b0, {1'b0, 1'b0, 8'h07});

        // Exhaustive 4-bit sweep on both serial and single-cycle configurations.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int mi = 0; mi < 2; mi++) begin
                    for (int si = 0; si < 2; si++) begin
                        @(posedge clk); #2;
                        a4 = 4'(ai); b4 = 4'(bi); m4 = 1'(mi); s4 = 1'(si);
                        iv1 = 1'b1; iv4 = 1'b1;
                        q1.push_back(ref4(ai, bi, 1'(mi), 1'(si)));
                        q4.push_back(ref4(ai, bi, 1'(mi), 1'(si)));
                        @(posedge clk); #1;
                        iv1 = 1'b0; iv4 = 1'b0;
                        t = 0;
                        while (!(ir1 && ir4) && t < 30) begin
                            @(posedge clk); #1;
                            t++;
                        end
                        if (t >= 30) timeout_fail("sweep_idle");
                    end
                end
            end
        end

        repeat (5) @(posedge clk);
        #1;
        chk("q8_drained", q8.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("q4_drained", q4.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
Parametrised, multi-cycle signed adder/subtractor. It is the sequential successor to the 4-bit combinational addsub block.
- Processes operands LSB-first, DIGIT bits per clock.
- Uses a valid/ready handshake on both the input side and the output side.
- Reports carry-out and signed overflow, and optionally saturates the result.
- Serves as the shared arithmetic unit for lab datapaths where area matters more than latency.

Parameters:
WIDTH, 8, operand/result width in bits (two's complement); WIDTH >= 2
DIGIT, 2, bits processed per RUN cycle; WIDTH % DIGIT == 0 (checked at elaboration, $error otherwise)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operands/mode/sat presented
in_ready  output  1  block can accept a new operation
mode  input  1  0 = a+b, 1 = a-b
sat  input  1  1 = saturate result on signed overflow
operand_a  input  WIDTH  signed operand a
operand_b  input  WIDTH  signed operand b
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  sum/difference (wrapped or saturated)
carry  output  1  raw carry-out of the WIDTH-bit add (sub: 1 = no borrow)
overflow  output  1  signed overflow of the true result

Behaviour:
- Reset (asynchronous, on rst_n low):
  - state = IDLE; in_ready = 1; out_valid = 0; result = 0; carry = 0; overflow = 0; internal shift/carry registers cleared.
  - Takes effect immediately, including mid-RUN or in DONE; any in-flight operation is discarded.
- States: IDLE, RUN, DONE. Let N = WIDTH/DIGIT.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1, latch a, (mode ? ~b : b), carry_in = mode, and sat.
  - Clear the cycle counter and go to RUN.
- RUN:
  - in_ready = 0; in_valid is ignored.
  - Each edge adds the low DIGIT bits of the a/b shift registers plus the running carry.
  - Shift the DIGIT sum bits into the result shift register from the top and shift a/b right by DIGIT.
  - Keep the carry into the MSB position (needed for overflow).
  - After the N-th RUN edge, go to DONE.
  - Latency: out_valid rises exactly N edges after the accepting edge (N = 1 when DIGIT = WIDTH).
- Entering DONE, register the outputs:
  - carry = final carry-out.
  - overflow = carry-into-MSB XOR carry-out.
  - If sat = 1 and overflow = 1: result = latched a sign bit ? 1000..0 (most negative) : 0111..1 (most positive). Otherwise result = wrapped WIDTH-bit sum.
  - overflow is reported regardless of sat.
- DONE:
  - out_valid = 1; in_ready = 0.
  - result/carry/overflow stay stable while out_ready = 0 (unbounded backpressure).
  - On an edge with out_ready = 1: out_valid drops and the state goes to IDLE; in_ready is 1 in the following cycle. There is no same-cycle accept in DONE.
- result/carry/overflow hold their last values in IDLE and RUN until the next DONE update.
- No X propagation: mode/sat/operands are sampled only on the accepting edge.

Test Plan:
(WIDTH=8, DIGIT=2 unless stated)
1. Add, no overflow: a=100, b=27, mode=0, sat=0 -> result=0x7F, overflow=0, carry=0; out_valid high exactly 4 edges after accept.
2. Add overflow:
   - a=100, b=28, sat=0 -> result=0x80, overflow=1, carry=0.
   - Same operands with sat=1 -> result=0x7F, overflow=1.
3. Subtract:
   - a=-128 (0x80), b=1, mode=1, sat=0 -> result=0x7F, overflow=1, carry=1.
   - sat=1 -> result=0x80.
   - a=5, b=7 -> result=0xFE, overflow=0, carry=0 (borrow).
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid, and pulse in_valid with new operands during RUN and DONE -> in_ready=0 throughout, outputs stable, pulses ignored. Raise out_ready -> out_valid falls next edge, in_ready=1 the cycle after.
5. Reset mid-operation: assert rst_n=0 after 2 RUN cycles -> in_ready=1, out_valid=0, result=0 immediately (asynchronous). Release reset and issue a=3, b=4, add -> result=0x07.
6. Exhaustive sweep, self-checked against a signed reference model:
   - WIDTH=4, DIGIT=1 and WIDTH=4, DIGIT=4, all a,b in [-8,7] for both modes and both sat values.
   - Expected result/overflow/carry must match for all 1024 cases per configuration; zero errors required.
